rstseq: RTL
===========

# rstseq

Parametrised reset sequencer. Holds a configurable number of downstream reset domains in reset after power-on reset or a filtered soft-reset request, then releases them one at a time in a fixed order with a programmable gap. It is the next generation of the single-output master reset generator and sits at the top level, driving the `reset_n` of each functional block (MIDI receivers, router core, transmitters). Outputs are active-low, matching the existing per-module `reset_n` convention.

## Interface
- `CHANNELS`, default 4: number of reset outputs; legal range 1..32.
- `HOLD_CYCLES`, default 16: cycles all outputs stay asserted after the trigger is removed; must be ≥1.
- `STAGGER_CYCLES`, default 4: cycles between successive channel releases; must be ≥1.
- `FILTER`, default 3: consecutive high samples of `req` needed to accept a soft reset; must be ≥1.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high master reset.
- `req`  in  1  soft-reset request, synchronous to `clk`.
- `reset_n`  out  CHANNELS  active-low reset per domain; bit 0 is released first.
- `done`  out  1  high when every channel is released.
- `reset_count`  out  8  number of accepted soft resets; saturates at 255.

## Operation
- Reset values: `reset_n` = all 0, `done` = 0, `reset_count` = 0, state HOLD, hold counter 0, filter counter 0.
- Filter: counts consecutive cycles with `req` high and clears when `req` is low.
  - `freq` (filtered request) is high while the count is ≥ FILTER.
  - It drops in the first cycle `req` is sampled low.
- Accepted event: the rising edge of `freq`. `reset_count` increments once per event, saturating at 255. Holding `req` high produces only one event.
- States:
  - HOLD: all `reset_n` = 0, `done` = 0. While `reset` or `freq` is high, the counter is held at 0. Otherwise it counts up. When it reaches HOLD_CYCLES-1, the state moves to STAGGER (or RUN when CHANNELS = 1), `reset_n[0]` goes to 1, and the channel index is set to 1.
  - STAGGER: a gap counter runs. Every STAGGER_CYCLES cycles, `reset_n[idx]` goes to 1 and `idx` increments. Releasing channel CHANNELS-1 moves the state to RUN and sets `done` = 1 on the same edge.
  - RUN: all `reset_n` = 1 and `done` = 1.
- `freq` high in any state:
  - on the next edge, all `reset_n` = 0, `done` = 0, state HOLD, counters cleared;
  - this applies in HOLD and STAGGER too, so a partially released sequence restarts from scratch.
- `reset` high dominates everything: on the next edge all state returns to reset values, including `reset_count`.
- Released channels never deassert out of order. At any time, `reset_n` is a thermometer code (bits 0..k are 1, the rest are 0).
- All outputs are registered. No combinational path exists from `req` or `reset` to any output.

## Timing
- Cycle 0 is the first edge at which `reset` is sampled low, with `req` low.
  - `reset_n[i]` rises at cycle HOLD_CYCLES + i·STAGGER_CYCLES.
  - `done` rises with `reset_n[CHANNELS-1]`.
- Soft reset: `req` is sampled high at cycles t..t+FILTER-1.
  - At cycle t+FILTER, all outputs drop and the count increments.
  - If the first low sample of `req` is at cycle u, then `reset_n[i]` rises at u + HOLD_CYCLES + i·STAGGER_CYCLES.
- A `req` pulse shorter than FILTER cycles has no effect.
- `reset` and `freq` together: `reset` wins and the count stays 0.
- Counter widths are sized to hold max(HOLD_CYCLES, STAGGER_CYCLES, FILTER). Counters never wrap, because they saturate or clear at their terminal value.

## Test plan
All scenarios use default parameters unless stated.
- Power-on: `reset` high 5 cycles, then low at cycle 0 → `reset_n` = 0000 through cycle 15, 0001@16, 0011@20, 0111@24, 1111@28; `done`@28; `reset_count` = 0.
- Glitch reject: in RUN, pulse `req` high for 2 cycles → `reset_n` stays 1111, `done` stays 1, `reset_count` stays 0.
- Soft reset: `req` high at cycles 40..44, low at 45 → `reset_n` = 0000 and `done` = 0 from 43; `reset_count` = 1 at 43; 0001@61, 1111@73.
- Restart mid-sequence: accept `req` while `reset_n` = 0011 → all bits 0 next edge; full sequence replays from the `req` low sample; `reset_count` increments.
- Reset mid-operation and saturation: issue 260 accepted requests → `reset_count` = 255. Then assert `reset` for 1 cycle → all outputs at reset values on the next edge.
- CHANNELS=1, HOLD_CYCLES=1, FILTER=1: release `reset` → `reset_n[0]` and `done` both high at cycle 1; a 1-cycle `req` drops them on the next edge.

Source files
------------

// File: rtl/rstseq.sv
// rstseq: parametrised reset sequencer.
// Holds CHANNELS active-low reset domains after power-on reset or a filtered
// soft-reset request, then releases them one at a time, bit 0 first.
module rstseq #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned FILTER         = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  output logic [CHANNELS-1:0] reset_n,
  output logic                done,
  output logic [7:0]          reset_count
);

  localparam int unsigned MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned MAX_C  = (MAX_HS > FILTER) ? MAX_HS : FILTER;
  localparam int unsigned CW     = $clog2(MAX_C + 1);
  localparam int unsigned IW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] FILT_MAX  = CW'(FILTER);
  localparam logic [IW-1:0] IDX_LAST  = IW'(CHANNELS - 1);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STAGGER = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       gap_q, gap_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CHANNELS-1:0] rn_q, rn_d;
  logic                done_q, done_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                freq_q;
  logic                boot_q;
  logic                freq;

  // Filtered request: high once FILTER consecutive high samples have been seen
  assign freq = (fcnt_q == FILT_MAX);

  // Next-state and next-output logic for the sequencer, filter and event counter
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rn_d    = rn_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    fcnt_d  = '0;

    if (req) begin
      fcnt_d = (fcnt_q == FILT_MAX) ? fcnt_q : fcnt_q + CW'(1);
    end

    if (freq && !freq_q && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (freq) begin
      state_d = S_HOLD;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rn_d    = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          rn_d   = '0;
          done_d = 1'b0;
          if (boot_q) begin
            // first cycle after master reset still counts as held
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            gap_d  = '0;
            idx_d  = IW'(1);
            rn_d   = CHANNELS'(1);
            if (CHANNELS == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_STAGGER;
            end
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
        S_STAGGER: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            // thermometer code: shift one more released bit in from the bottom
            rn_d  = (rn_q << 1) | CHANNELS'(1);
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            gap_d = gap_q + CW'(1);
          end
        end
        S_RUN: begin
          rn_d   = '1;
          done_d = 1'b1;
        end
        default: begin
          state_d = S_HOLD;
          hold_d  = '0;
          gap_d   = '0;
          idx_d   = '0;
          rn_d    = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous master reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      fcnt_q  <= '0;
      idx_q   <= '0;
      rn_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      freq_q  <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      rn_q    <= rn_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq;
      boot_q  <= 1'b0;
    end
  end

  assign reset_n     = rn_q;
  assign done        = done_q;
  assign reset_count = cnt_q;

endmodule
